level_sequencer: RTL and testbench
==================================

Name: level_sequencer

Overview:
- Parametrised successor to the fixed three-level note selector.
- Selects one of NUM_LEVELS external synchronous note ROMs and generates the ROM address itself.
- Steps through the song one note per beat_tick, with start/pause/abort control and end-of-song signalling.
- Sits between the beat generator and the arrow-scroll/judge logic; emits a one-cycle note_valid strobe per beat.

Parameters:
- NUM_LEVELS, 4, number of level ROMs on the flattened input bus (≥1).
- LEVEL_W, 2, width of level_num; must satisfy 2^LEVEL_W ≥ NUM_LEVELS.
- ADDR_WIDTH, 6, ROM address width.
- DATA_WIDTH, 4, note width; one bit per arrow lane.
- SONG_LEN, 64, notes per song; 1 ≤ SONG_LEN ≤ 2^ADDR_WIDTH.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins a song, honoured only in IDLE or DONE.
- abort  in  1  returns to IDLE from any state.
- pause  in  1  level-sensitive; holds playback while high.
- level_num  in  LEVEL_W  level index, 0-based; sampled only on an accepted start.
- beat_tick  in  1  one-cycle beat strobe; spacing ≥2 clk.
- rom_addr  out  ADDR_WIDTH  shared address to all level ROMs.
- rom_data  in  NUM_LEVELS*DATA_WIDTH  ROM outputs; level k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]; 1-cycle read latency.
- note  out  DATA_WIDTH  registered note for the current beat.
- note_valid  out  1  one-cycle strobe when note updates.
- busy  out  1  high in LOAD, PLAY, PAUSED.
- done  out  1  high in DONE.
- level_q  out  LEVEL_W  latched active level.

Behaviour:
- Reset: state=IDLE; rom_addr=0, note=0, note_valid=0, busy=0, done=0, level_q=0.
- States: IDLE, LOAD, PLAY, PAUSED, DONE.
- Start: in IDLE or DONE, start=1 -> level_q<=level_num, or 0 if level_num≥NUM_LEVELS; rom_addr<=0; go to LOAD. start is ignored in all other states.
- LOAD: lasts exactly one cycle to cover ROM latency, then PLAY. beat_tick in LOAD is dropped.
- PLAY, beat_tick=1 and pause=0:
  - note<=rom_data slice[level_q]; note_valid<=1 on the next edge.
  - If rom_addr==SONG_LEN-1 -> DONE, rom_addr held.
  - Otherwise rom_addr<=rom_addr+1.
- Beat latency: beat_tick at edge t -> note/note_valid visible after edge t+1. The ROM address is therefore always stable ≥1 cycle before sampling.
- Pause: pause=1 in PLAY -> PAUSED. Ticks while paused are dropped. pause=0 -> PLAY, same rom_addr. pause and tick in the same PLAY cycle: pause wins, no note.
- abort: -> IDLE, note<=0, rom_addr<=0. Priority order: rst > abort > start > pause > tick.
- note holds its last value between strobes; note_valid=0 except on strobe cycles.
- DONE: done=1, note holds the last value; start restarts, possibly with a new level.
- rom_addr arithmetic is ADDR_WIDTH wide; it never exceeds SONG_LEN-1, so there is no wrap.
- Reset mid-song: immediate return to reset values; no strobe that cycle.
- Changes on level_num after start have no effect until the next accepted start.

Optional Feature:
- Macro: LEVEL_SEQ_LOOP_EN.
- Defined: on the tick at SONG_LEN-1, rom_addr<=0 and the state stays PLAY, so the song loops endlessly; done never asserts.
- Undefined: behaviour as above, ending in DONE.

Decomposition:
- Shared package ddr_pkg: state encoding constants (IDLE=0 … DONE=4), the note lane bit positions (LEFT, DOWN, UP, RIGHT), and the default DATA_WIDTH/ADDR_WIDTH.
- One natural sub-module, level_mux: parametrised combinational slice select of rom_data by level_q, including the out-of-range-to-0 handling.
- FSM, address counter and output register stay in level_sequencer.

Test Plan:
- Reset then idle: rst 2 cycles, random ticks -> rom_addr=0, note=0, note_valid never 1, busy=0.
- Basic play: ROM model level 2 holds addr[3:0]; start, level_num=2, ticks every 4 clk -> note sequence 0,1,2,…,15,0,…; each note_valid 1 cycle after its tick; done after the 64th note.
- Level clamp: NUM_LEVELS=3, level_num=3 -> level_q=0, notes taken from the level 0 ROM.
- Pause: pause high across 3 ticks after note 5 -> no strobes; after release the next note is 6; pause and tick in the same cycle -> no strobe.
- Abort/restart: abort at addr 10 -> IDLE, note=0; start with level 1 -> notes restart from addr 0 of level 1; start while PLAY is ignored.
- Loop macro: with LEVEL_SEQ_LOOP_EN and SONG_LEN=4 -> notes for addr 0,1,2,3,0,1,…; done stays 0.

Source files
------------

// File: rtl/ddr_pkg.sv
// Shared definitions for the note-sequencing path: state encoding,
// arrow lane bit positions and default ROM geometry.
package ddr_pkg;

  localparam int DEF_ADDR_WIDTH = 6;
  localparam int DEF_DATA_WIDTH = 4;

  // One bit per arrow lane inside a note word
  localparam int LANE_LEFT  = 0;
  localparam int LANE_DOWN  = 1;
  localparam int LANE_UP    = 2;
  localparam int LANE_RIGHT = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_PLAY   = 3'd2,
    ST_PAUSED = 3'd3,
    ST_DONE   = 3'd4
  } seq_state_e;

endpackage

// File: rtl/level_mux.sv
// Combinational selection of one level's note out of the flattened
// ROM data bus. An index with no ROM behind it yields an all-zero note.
module level_mux
  import ddr_pkg::*;
#(
  parameter int NUM_LEVELS = 4,
  parameter int LEVEL_W    = 2,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic [NUM_LEVELS*DATA_WIDTH-1:0] rom_data,
  input  logic [LEVEL_W-1:0]               level_sel,
  output logic [DATA_WIDTH-1:0]            note_sel
);

  logic [NUM_LEVELS-1:0][DATA_WIDTH-1:0] slices;

  for (genvar k = 0; k < NUM_LEVELS; k++) begin : g_slice
    assign slices[k] = rom_data[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // Compare against every real level so out-of-range indices fall through to 0
  always_comb begin
    note_sel = '0;
    for (int k = 0; k < NUM_LEVELS; k++) begin
      if (level_sel == LEVEL_W'(k)) note_sel = slices[k];
    end
  end

endmodule

// File: rtl/level_sequencer.sv
// Level sequencer: picks one of NUM_LEVELS note ROMs, drives the shared
// ROM address and emits one note per accepted beat_tick.
// Optional build macro LEVEL_SEQ_LOOP_EN: the song wraps to address 0
// at its end instead of stopping in DONE.
module level_sequencer
  import ddr_pkg::*;
#(
  parameter int NUM_LEVELS = 4,
  parameter int LEVEL_W    = 2,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int SONG_LEN   = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             abort,
  input  logic                             pause,
  input  logic [LEVEL_W-1:0]               level_num,
  input  logic                             beat_tick,
  output logic [ADDR_WIDTH-1:0]            rom_addr,
  input  logic [NUM_LEVELS*DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0]            note,
  output logic                             note_valid,
  output logic                             busy,
  output logic                             done,
  output logic [LEVEL_W-1:0]               level_q
);

  seq_state_e state, state_nx;
  logic       take_start, take_tick, last;
  // [0]: tick accepted last edge (ROM data settles), [1]: note strobe
  logic [1:0] vld_pipe;
  logic [DATA_WIDTH-1:0] note_sel;
  logic [LEVEL_W-1:0]    level_clamp;

  level_mux #(
    .NUM_LEVELS(NUM_LEVELS),
    .LEVEL_W   (LEVEL_W),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mux (
    .rom_data (rom_data),
    .level_sel(level_q),
    .note_sel (note_sel)
  );

  assign last        = (rom_addr == ADDR_WIDTH'(SONG_LEN - 1));
  assign level_clamp = (int'(level_num) < NUM_LEVELS) ? level_num : '0;
  assign note_valid  = vld_pipe[1];
  assign busy        = (state == ST_LOAD) || (state == ST_PLAY) || (state == ST_PAUSED);
  assign done        = (state == ST_DONE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next state and accept strobes; abort beats start beats pause beats tick
  always_comb begin
    state_nx   = state;
    take_start = 1'b0;
    take_tick  = 1'b0;
    if (abort) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: if (start) begin
          state_nx   = ST_LOAD;
          take_start = 1'b1;
        end
        ST_LOAD: state_nx = ST_PLAY;
        ST_PLAY: begin
          if (pause) begin
            state_nx = ST_PAUSED;
          end else if (beat_tick) begin
            take_tick = 1'b1;
`ifndef LEVEL_SEQ_LOOP_EN
            if (last) state_nx = ST_DONE;
`endif
          end
        end
        ST_PAUSED: if (!pause) state_nx = ST_PLAY;
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // Address counter, level latch and note register; the note is captured
  // one edge after its tick, when the ROM output for that address is valid
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr <= '0;
      note     <= '0;
      vld_pipe <= '0;
      level_q  <= '0;
    end else if (abort) begin
      rom_addr <= '0;
      note     <= '0;
      vld_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], take_tick};
      if (vld_pipe[0]) note <= note_sel;
      if (take_start) begin
        rom_addr <= '0;
        level_q  <= level_clamp;
      end else if (take_tick) begin
`ifdef LEVEL_SEQ_LOOP_EN
        rom_addr <= last ? '0 : rom_addr + 1'b1;
`else
        if (!last) rom_addr <= rom_addr + 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_level_sequencer.sv
// Bench for level_sequencer with three level ROMs. Expected notes are
// queued when an accepted tick is driven and popped on each note_valid.
module tb_level_sequencer;

  localparam int NL = 3, LW = 2, AW = 6, DW = 4, SL = 64;
  localparam int M_IDLE = 0, M_PLAY = 1, M_PAUSED = 2, M_DONE = 3;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, pause = 1'b0, beat_tick = 1'b0;
  logic [LW-1:0]    level_num = '0;
  logic [AW-1:0]    rom_addr;
  logic [NL*DW-1:0] rom_data = '0;
  logic [DW-1:0]    note;
  logic             note_valid, busy, done;
  logic [LW-1:0]    level_q;

  typedef struct {
    logic [DW-1:0] note;
    int            cyc;
  } sb_t;
  sb_t sb[$];

  int n_chk = 0, n_fail = 0, cyc = 0;
  int m_state = M_IDLE, exp_addr = 0, exp_lvl = 0;

  level_sequencer #(.NUM_LEVELS(NL), .LEVEL_W(LW), .ADDR_WIDTH(AW),
                    .DATA_WIDTH(DW), .SONG_LEN(SL)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .pause(pause),
    .level_num(level_num), .beat_tick(beat_tick), .rom_addr(rom_addr),
    .rom_data(rom_data), .note(note), .note_valid(note_valid),
    .busy(busy), .done(done), .level_q(level_q)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_val(input int lvl, input logic [AW-1:0] a);
    case (lvl)
      0:       return a[3:0] ^ 4'h5;
      1:       return ~a[3:0];
      default: return a[3:0];
    endcase
  endfunction

  // Synchronous ROMs, one-cycle read latency
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < NL; k++) rom_data[k*DW +: DW] <= rom_val(k, rom_addr);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Scoreboard: every strobe must match the oldest pending note and latency
  always @(negedge clk) begin
    if (note_valid) begin
      if (sb.size() == 0) chk("spurious_strobe", 32'd1, 32'd0);
      else begin
        sb_t e;
        e = sb.pop_front();
        chk("note", 32'(note), 32'(e.note));
        chk("latency", cyc, e.cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic beat();
    sb_t e;
    beat_tick = 1'b1;
    if (m_state == M_PLAY && pause) m_state = M_PAUSED;
    else if (m_state == M_PLAY) begin
      e.note = rom_val(exp_lvl, AW'(exp_addr));
      e.cyc  = cyc + 2;
      sb.push_back(e);
      if (exp_addr == SL - 1) begin
`ifdef LEVEL_SEQ_LOOP_EN
        exp_addr = 0;
`else
        m_state = M_DONE;
`endif
      end else exp_addr++;
    end
    step();
    beat_tick = 1'b0;
    repeat (3) step();
    chk("addr", 32'(rom_addr), 32'(exp_addr));
  endtask

  task automatic do_start(input int lvl, input bit tick_in_load);
    start = 1'b1;
    level_num = lvl[LW-1:0];
    step();
    start = 1'b0;
    if (m_state == M_IDLE || m_state == M_DONE) begin
      m_state  = M_PLAY;
      exp_lvl  = (lvl < NL) ? lvl : 0;
      exp_addr = 0;
    end
    beat_tick = tick_in_load;
    step();
    beat_tick = 1'b0;
    step();
    level_num = 2'd1;  // later changes must not affect the active level
    chk("level_q", 32'(level_q), 32'(exp_lvl));
    chk("busy_play", 32'(busy), 32'd1);
  endtask

  task automatic do_abort();
    abort = 1'b1;
    step();
    abort = 1'b0;
    m_state = M_IDLE;
    exp_addr = 0;
    chk("abort_note", 32'(note), 32'd0);
    chk("abort_addr", 32'(rom_addr), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
  endtask

  task automatic set_pause(input bit p);
    pause = p;
    step();
    if (m_state == M_PLAY && p) m_state = M_PAUSED;
    else if (m_state == M_PAUSED && !p) m_state = M_PLAY;
  endtask

  initial begin
    // Reset and idle
    repeat (2) step();
    rst = 1'b0;
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("rst_note", 32'(note), 32'd0);
    chk("rst_valid", 32'(note_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_level", 32'(level_q), 32'd0);
    for (int i = 0; i < 8; i++) begin
      beat_tick = 1'($urandom_range(0, 1));
      step();
      beat_tick = 1'b0;
      step();
    end
    chk("idle_addr", 32'(rom_addr), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // Full song on level 2, with a dropped tick during LOAD
    do_start(2, 1'b1);
    for (int i = 0; i < SL; i++) beat();
`ifdef LEVEL_SEQ_LOOP_EN
    chk("loop_done", 32'(done), 32'd0);
    chk("loop_busy", 32'(busy), 32'd1);
    repeat (3) beat();
`else
    chk("end_done", 32'(done), 32'd1);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_note_hold", 32'(note), 32'(rom_val(2, AW'(SL - 1))));
    beat();  // ignored in DONE
    // Restart from DONE straight into the clamp case
    do_start(3, 1'b0);
    repeat (4) beat();
`endif
    do_abort();

    // Out-of-range level falls back to level 0
    do_start(3, 1'b0);
    chk("clamp_level", 32'(level_q), 32'd0);
    repeat (5) beat();
    do_abort();

    // Pause holds playback; pause wins over a coincident tick
    do_start(2, 1'b0);
    repeat (6) beat();
    set_pause(1'b1);
    chk("paused_busy", 32'(busy), 32'd1);
    repeat (3) beat();
    set_pause(1'b0);
    beat();
    pause = 1'b1;
    beat();
    set_pause(1'b0);
    beat();
    chk("pause_addr", 32'(rom_addr), 32'd8);

    // Abort at address 10, restart on level 1, start while playing ignored
    while (exp_addr < 10) beat();
    do_abort();
    do_start(1, 1'b0);
    repeat (3) beat();
    do_start(0, 1'b0);
    chk("ignored_start_level", 32'(level_q), 32'd1);
    repeat (3) beat();

    // Reset mid-song drops any pending note
    beat_tick = 1'b1;
    step();
    beat_tick = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    m_state = M_IDLE;
    chk("midrst_valid", 32'(note_valid), 32'd0);
    chk("midrst_note", 32'(note), 32'd0);
    chk("midrst_level", 32'(level_q), 32'd0);
    repeat (4) step();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
